// File: rtl/bitbal_pkg.sv
// Shared definitions for the bit-balancing datapath:
// pattern width, FSM states and a popcount helper.
package bitbal_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CW    = $clog2(DEF_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int popcount(input logic [31:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++)
      n += int'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/bresenham_step.sv
// One Bresenham step: decides the current bit and the
// residual accumulator for the next position.
module bresenham_step
  import bitbal_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic [CW-1:0] acc,
  input  logic [CW-1:0] cnt,
  output logic          out_bit,
  output logic [CW-1:0] next_acc
);

  localparam logic [CW:0] W_S = (CW+1)'(WIDTH);

  logic [CW:0] sum;
  logic [CW:0] rem;

  // One extra bit so acc + cnt never wraps.
  assign sum      = {1'b0, acc} + {1'b0, cnt};
  assign out_bit  = (sum >= W_S);
  assign rem      = out_bit ? (sum - W_S) : sum;
  assign next_acc = rem[CW-1:0];

endmodule

// File: rtl/bit_spreader.sv
// Turns a ones-count into an evenly spread WIDTH-bit
// pattern, streamed LSB-first and then latched as a word.
module bit_spreader
  import bitbal_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CW-1:0]    in_count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_bit,
  output logic             out_last,
  output logic [WIDTH-1:0] word,
  output logic             word_valid,
  output logic             sat
);

  localparam int          IW  = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] W_C = CW'(WIDTH);
  localparam logic [IW-1:0] I_L = IW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    acc;
  logic [CW-1:0]    acc_nxt;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_nxt;
  logic             sat_pend;
  logic             step_bit;
  logic             run;

  bresenham_step #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_step (
    .acc      (acc),
    .cnt      (cnt),
    .out_bit  (step_bit),
    .next_acc (acc_nxt)
  );

  assign run        = (state == RUN);
  assign in_ready   = reset_n && (state == IDLE);
  assign out_valid  = run;
  assign out_bit    = run && step_bit;
  assign out_last   = run && (idx == I_L);
  assign word_valid = (state == DONE);

  // Final bit goes straight into word at the last handshake.
  always_comb begin
    shreg_nxt      = shreg;
    shreg_nxt[idx] = step_bit;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      idx      <= '0;
      shreg    <= '0;
      sat_pend <= 1'b0;
      word     <= '0;
      sat      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            cnt      <= (in_count > W_C) ? W_C : in_count;
            sat_pend <= (in_count > W_C);
            acc      <= '0;
            idx      <= '0;
            shreg    <= '0;
            state    <= RUN;
          end
        end
        RUN: begin
          if (out_ready) begin
            acc   <= acc_nxt;
            shreg <= shreg_nxt;
            idx   <= idx + IW'(1);
            if (idx == I_L) begin
              word  <= shreg_nxt;
              sat   <= sat_pend;
              state <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/bit_spreader.md
# bit_spreader

Inverse of the bit-count block. It accepts a ones-count (0..WIDTH) through a valid/ready handshake and emits a WIDTH-bit pattern that contains exactly that many ones, spread evenly. The pattern is produced by a Bresenham accumulator and sent out LSB-first as a serial stream with its own valid/ready handshake. On completion, the assembled parallel word is presented with a one-cycle strobe. Its job is to regenerate balanced test patterns and calibration words for the bit-balancing datapath, so that counter → spreader → counter is an identity loop.

## Interface
- WIDTH, 8, pattern length in bits; must be ≥ 2.
- CW, $clog2(WIDTH+1) (4), width of the count field.
- clk  input  1  single clock; everything is sampled on its rising edge.
- reset_n  input  1  asynchronous, active-low reset; clears all state.
- in_valid  input  1  in_count is valid.
- in_ready  output  1  block can accept a count; high only in IDLE.
- in_count  input  CW  requested number of ones.
- out_valid  output  1  out_bit is valid.
- out_ready  input  1  downstream accepts out_bit.
- out_bit  output  1  current pattern bit; LSB (bit 0) first.
- out_last  output  1  high with the final bit (index WIDTH-1).
- word  output  WIDTH  last completed pattern; held until the next completion.
- word_valid  output  1  one-cycle strobe when word updates.
- sat  output  1  last accepted in_count exceeded WIDTH and was clamped; updates with word.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - in_ready=1, out_valid=0.
  - When in_valid and in_ready are both high:
    - cnt := min(in_count, WIDTH)
    - sat_pend := (in_count > WIDTH)
    - acc := 0, idx := 0, shreg := 0
    - go to RUN.
- **RUN**
  - out_valid=1, in_ready=0.
  - sum = acc + cnt, computed combinationally at CW+1 bits so it cannot overflow.
  - out_bit = (sum ≥ WIDTH).
  - out_last = (idx == WIDTH-1).
  - When out_valid and out_ready are both high:
    - acc := out_bit ? sum − WIDTH : sum
    - shreg[idx] := out_bit
    - idx := idx + 1
    - if out_last, go to DONE.
  - While out_ready is low: acc, idx, out_bit and out_last hold stable.
- **DONE** (exactly one cycle)
  - word := shreg with the final bit included. The final bit is written into word directly at the last handshake, so word is complete in DONE.
  - word_valid=1, sat := sat_pend.
  - in_ready=0, out_valid=0.
  - Go to IDLE.
- Invariants:
  - The popcount of every emitted word equals cnt.
  - cnt=0 gives all zeros; cnt=WIDTH gives all ones.
  - acc stays in the range 0..WIDTH-1 at all times.
- Outputs after reset:
  - in_ready=0 during reset, then 1 in the first cycle after deassertion (state IDLE).
  - out_valid=0, out_bit=0, out_last=0, word=0, word_valid=0, sat=0.
  - FSM=IDLE, acc=0, idx=0.
- Reset asserted mid-operation aborts the pattern immediately: no word_valid, word returns to 0, and no partial word is presented.
- An in_valid pulse that arrives while in_ready=0 is ignored. The upstream side must hold in_valid until the handshake completes.

## Timing
- A count accepted at edge N makes bit 0 valid in the cycle after edge N.
- With out_ready held high:
  - bit k is transferred at edge N+1+k.
  - the DONE cycle, with word_valid=1, follows edge N+WIDTH.
  - in_ready returns to 1 after edge N+WIDTH+1.
- Throughput is one pattern per WIDTH+2 cycles.
- Each stall cycle with out_ready=0 adds exactly one cycle to this latency.
- out_bit and out_last are combinational from registered state only; there is no path from out_ready to out_bit.
- in_ready and word_valid are decoded from the FSM state register.

## Structure
- A shared package `bitbal_pkg` holds:
  - the WIDTH default and CW derivation;
  - the FSM state typedef (IDLE/RUN/DONE);
  - a `popcount` function used by the bench scoreboard and reusable by the counter block.
- Sub-module `bresenham_step`: combinational; inputs acc and cnt, outputs out_bit and next_acc. All other logic stays in the top module.

## Test plan
- Reset then in_count=3, out_ready=1 → serial bits 0,0,1,0,0,1,0,1; word=8'hA4; word_valid pulse 9 cycles after accept; sat=0.
- Sweep in_count 0..8, back-to-back → words 00,80,88,A4,AA,DA,EE,FE,FF (each with popcount = count); in_ready low for exactly WIDTH+1 cycles per pattern.
- in_count=12 → word=8'hFF, sat=1; a following in_count=2 → word=8'h88, sat=0.
- in_count=5 with out_ready toggled randomly → identical bit sequence (word=8'hDA); out_bit and out_last stable during every stall; latency grows by the number of stall cycles.
- reset_n pulsed low after bit 4 of in_count=7 → all outputs 0 asynchronously; no word_valid; the next request (in_count=1) produces word=8'h80 correctly.
- in_valid asserted during RUN with a different count → ignored; the current pattern completes unchanged.
